m_conv_collect: RTL and testbench
=================================

M_CONV_COLLECT -- requirements
Module: m_conv_collect

Interface
REQ-001 SHALL provide parameter NUM_OUT, default 13'd7744, meaning the number of conv output words per feature map (88x88).
REQ-002 SHALL provide parameter ADDR_W, default 13, meaning the width of the buffer address and counters.
REQ-003 clk_in  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-high despite the name; asserting it forces the reset state immediately.
REQ-005 collect_en  input  1  enables collection; driven together with the conv layer start.
REQ-006 map_in  input  16  signed conv result word, taken from the conv layer map_out.
REQ-007 save  input  1  qualifies map_in; one word per cycle while high.
REQ-008 rd_start  input  1  downstream request to stream out the buffered map.
REQ-009 data_out  output  16  ReLU'd stored word being streamed out.
REQ-010 out_valid  output  1  data_out is valid this cycle.
REQ-011 out_last  output  1  high with the final streamed word (address NUM_OUT-1).
REQ-012 full  output  1  buffer holds a complete map and is awaiting rd_start.
REQ-013 wr_cnt  output  ADDR_W  number of words written in the current collection.
REQ-014 ovf_err  output  1  sticky flag: save seen when no write was permitted.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, FULL, STREAM; the reset state is IDLE.
REQ-016 IDLE: collect_en=1 -> COLLECT; wr_cnt cleared to 0 on entry.
REQ-017 COLLECT: on each save=1 cycle, SHALL write ReLU(map_in) at address wr_cnt and increment wr_cnt.
REQ-018 ReLU rule: map_in[15]=1 -> 16'd0 is stored; otherwise map_in is stored unchanged. No other arithmetic is applied.
REQ-019 A write at address NUM_OUT-1 SHALL move the FSM to FULL on the next cycle, with wr_cnt=NUM_OUT.
REQ-020 COLLECT with collect_en=0 SHALL abort to IDLE, clear wr_cnt, and leave buffer contents undefined.
REQ-021 FULL: full=1; further save pulses SHALL NOT write and SHALL set ovf_err; collect_en is ignored.
REQ-022 save=1 in IDLE or STREAM SHALL set ovf_err with no write.
REQ-023 FULL and rd_start=1 -> STREAM, with read address 0 presented on the first STREAM cycle.
REQ-024 STREAM: read address increments by 1 every cycle from 0 to NUM_OUT-1; no backpressure.
REQ-025 The buffer read SHALL be registered: out_valid first rises the cycle after STREAM is entered, then stays high for exactly NUM_OUT consecutive cycles.
REQ-026 data_out on the k-th valid cycle (k=0..NUM_OUT-1) SHALL equal the value written at address k.
REQ-027 out_last SHALL be high only on the final valid cycle; the FSM SHALL return to IDLE on the same edge that presents that final word.
REQ-028 data_out SHALL hold 0 whenever out_valid=0.
REQ-029 Save and rd_start arriving in the same cycle: in COLLECT, rd_start is ignored; in FULL, save sets ovf_err and rd_start is honoured.
REQ-030 The buffer SHALL be inferred as a single-port block RAM of NUM_OUT x 16 bits.

Reset
REQ-031 When rst_n=1: FSM=IDLE, wr_cnt=0, read address=0, data_out=0, out_valid=0, out_last=0, full=0, ovf_err=0.
REQ-032 Reset mid-COLLECT or mid-STREAM SHALL abort immediately with no further writes or valid words; RAM contents are not cleared.
REQ-033 ovf_err SHALL be cleared only by reset.

Verification
REQ-034 NUM_OUT=4; collect_en=1; save on 4 consecutive cycles with map_in=5,-3,32767,-32768 -> full=1, wr_cnt=4; rd_start pulse -> out_valid for 4 cycles with data 5,0,32767,0, out_last on the 4th, then IDLE.
REQ-035 NUM_OUT=4; save gapped (1,0,1,1,0,1) with map_in=1..4 on the save cycles -> stored and streamed 1,2,3,4; full rises the cycle after the 4th save.
REQ-036 In FULL, save=1 with map_in=9 -> ovf_err=1, and streamed data unchanged.
REQ-037 Collect 2 of 4 words, then collect_en=0 -> IDLE, wr_cnt=0, full=0; a fresh collection of 4 words succeeds.
REQ-038 rst_n pulsed at the 2nd STREAM valid cycle -> out_valid=0 and data_out=0 immediately, FSM=IDLE, ovf_err=0.
REQ-039 Default NUM_OUT=7744 with a ramp input (map_in=addr) -> 7744 valid words equal to 0..7743, out_last only on word 7743.

Source files
------------

// File: rtl/m_conv_collect.sv
// Collects one conv feature map (ReLU applied on write) into a single-port RAM,
// then streams it out in address order once the downstream asks for it.
module m_conv_collect #(
  parameter int                ADDR_W  = 13,
  parameter logic [ADDR_W-1:0] NUM_OUT = 13'd7744
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              collect_en,
  input  logic [15:0]       map_in,
  input  logic              save,
  input  logic              rd_start,
  output logic [15:0]       data_out,
  output logic              out_valid,
  output logic              out_last,
  output logic              full,
  output logic [ADDR_W-1:0] wr_cnt,
  output logic              ovf_err,
  output logic [1:0]        state_dbg
);

  localparam int                RAM_AW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [ADDR_W-1:0] LAST   = NUM_OUT - 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    STREAM  = 2'd3
  } state_t;

  // Handshake: save qualifies map_in for one word per cycle; out_valid marks
  // data_out for one word per cycle with no backpressure; out_last tags the final word.

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              we;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       relu_word;
  logic [15:0]       ram_q;
  logic [15:0]       mem [0:NUM_OUT-1];

  assign relu_word = map_in[15] ? 16'd0 : map_in;
  assign ram_addr  = (state_q == STREAM) ? rd_addr_q[RAM_AW-1:0] : wr_cnt_q[RAM_AW-1:0];

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_addr_d = rd_addr_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (save) ovf_d = 1'b1;
        if (collect_en) begin
          state_d  = COLLECT;
          wr_cnt_d = '0;
        end
      end
      COLLECT: begin
        if (!collect_en) begin
          state_d  = IDLE;
          wr_cnt_d = '0;
          if (save) ovf_d = 1'b1;
        end else if (save) begin
          we       = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST) state_d = FULL;
        end
      end
      FULL: begin
        if (save) ovf_d = 1'b1;
        if (rd_start) begin
          state_d   = STREAM;
          rd_addr_d = '0;
        end
      end
      STREAM: begin
        if (save) ovf_d = 1'b1;
        valid_d   = 1'b1;
        last_d    = (rd_addr_q == LAST);
        rd_addr_d = rd_addr_q + 1'b1;
        // Leave on the edge that registers the final word.
        if (rd_addr_q == LAST) begin
          state_d   = IDLE;
          rd_addr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      rd_addr_q <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_addr_q <= rd_addr_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  // Single shared address port; contents deliberately survive reset.
  always_ff @(posedge clk_in) begin
    if (we) mem[ram_addr] <= relu_word;
    ram_q <= mem[ram_addr];
  end

  assign data_out  = valid_q ? ram_q : 16'd0;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign full      = (state_q == FULL);
  assign wr_cnt    = wr_cnt_q;
  assign ovf_err   = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_m_conv_collect.sv
// Directed bench for m_conv_collect: a 4-word instance for the corner cases and
// a default-size instance streamed with a ramp.
module tb_m_conv_collect;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en, sv, rs;
  logic [15:0] mi;
  logic [15:0] dout;
  logic        vld, lst, full;
  logic [12:0] wcnt;
  logic        ovf;
  logic [1:0]  st;

  logic        en_b, sv_b, rs_b;
  logic [15:0] mi_b;
  logic [15:0] dout_b;
  logic        vld_b, lst_b, full_b;
  logic [12:0] wcnt_b;
  logic        ovf_b;
  logic [1:0]  st_b;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  m_conv_collect #(.NUM_OUT(13'd4)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .collect_en(en), .map_in(mi), .save(sv),
    .rd_start(rs), .data_out(dout), .out_valid(vld), .out_last(lst),
    .full(full), .wr_cnt(wcnt), .ovf_err(ovf), .state_dbg(st)
  );

  m_conv_collect dut_big (
    .clk_in(clk_in), .rst_n(rst_n), .collect_en(en_b), .map_in(mi_b), .save(sv_b),
    .rd_start(rs_b), .data_out(dout_b), .out_valid(vld_b), .out_last(lst_b),
    .full(full_b), .wr_cnt(wcnt_b), .ovf_err(ovf_b), .state_dbg(st_b)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Collect four words on consecutive cycles into the small instance.
  task automatic collect4(input logic [15:0] w0, w1, w2, w3);
    en = 1'b1;
    tick();
    chk("collect_state", {30'd0, st}, 32'd1);
    sv = 1'b1;
    mi = w0; tick();
    mi = w1; tick();
    mi = w2; tick();
    mi = w3; tick();
    sv = 1'b0;
    en = 1'b0;
    chk("full_after_4", {31'd0, full}, 32'd1);
    chk("wr_cnt_4", {19'd0, wcnt}, 32'd4);
  endtask

  // Stream the small instance and compare against exp_q (front first).
  task automatic stream4(input string tag);
    logic [15:0] e;
    rs = 1'b1;
    tick();
    rs = 1'b0;
    chk({tag, "_first_cycle_invalid"}, {31'd0, vld}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
      chk({tag, "_valid"}, {31'd0, vld}, 32'd1);
      chk({tag, "_data"}, {16'd0, dout}, {16'd0, e});
      chk({tag, "_last"}, {31'd0, lst}, (k == 3) ? 32'd1 : 32'd0);
    end
    chk({tag, "_idle_after"}, {30'd0, st}, 32'd0);
    tick();
    chk({tag, "_valid_drop"}, {31'd0, vld}, 32'd0);
    chk({tag, "_data_zero"}, {16'd0, dout}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    en = 1'b0; sv = 1'b0; rs = 1'b0; mi = 16'd0;
    en_b = 1'b0; sv_b = 1'b0; rs_b = 1'b0; mi_b = 16'd0;
    tick();
    tick();
    chk("rst_valid", {31'd0, vld}, 32'd0);
    chk("rst_data", {16'd0, dout}, 32'd0);
    chk("rst_last", {31'd0, lst}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_wr_cnt", {19'd0, wcnt}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_state", {30'd0, st}, 32'd0);
    rst_n = 1'b0;
    tick();

    // ReLU on write: negatives become zero, positives unchanged.
    collect4(16'd5, 16'hFFFD, 16'd32767, 16'h8000);
    chk("ovf_clean", {31'd0, ovf}, 32'd0);
    exp_q = '{16'd5, 16'd0, 16'd32767, 16'd0};
    stream4("relu");

    // Gapped saves 1,0,1,1,0,1 carrying words 1..4.
    en = 1'b1;
    tick();
    begin
      logic [5:0] pat;
      logic [15:0] w;
      pat = 6'b101101;
      w = 16'd1;
      for (int i = 0; i < 6; i++) begin
        sv = pat[5-i];
        mi = pat[5-i] ? w : 16'h7777;
        if (pat[5-i]) w = w + 16'd1;
        tick();
        if (i == 4) chk("gap_not_full_yet", {31'd0, full}, 32'd0);
        if (i == 4) chk("gap_wr_cnt_3", {19'd0, wcnt}, 32'd3);
      end
    end
    sv = 1'b0;
    en = 1'b0;
    chk("gap_full", {31'd0, full}, 32'd1);

    // Save while FULL must flag overflow and not disturb the buffer.
    sv = 1'b1; mi = 16'd9;
    tick();
    sv = 1'b0;
    chk("full_ovf", {31'd0, ovf}, 32'd1);
    chk("full_stays", {31'd0, full}, 32'd1);
    chk("full_wr_cnt", {19'd0, wcnt}, 32'd4);
    exp_q = '{16'd1, 16'd2, 16'd3, 16'd4};
    stream4("gap");
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Abort after two words, then a clean collection with rd_start ignored in COLLECT.
    en = 1'b1;
    tick();
    sv = 1'b1;
    mi = 16'd10; tick();
    mi = 16'd11; tick();
    sv = 1'b0;
    en = 1'b0;
    tick();
    chk("abort_state", {30'd0, st}, 32'd0);
    chk("abort_wr_cnt", {19'd0, wcnt}, 32'd0);
    chk("abort_full", {31'd0, full}, 32'd0);
    en = 1'b1;
    tick();
    sv = 1'b1; rs = 1'b1; mi = 16'd20; tick();
    rs = 1'b0;
    chk("rd_start_ignored", {30'd0, st}, 32'd1);
    mi = 16'd21; tick();
    mi = 16'd22; tick();
    mi = 16'd23; tick();
    sv = 1'b0; en = 1'b0;
    chk("fresh_full", {31'd0, full}, 32'd1);
    chk("fresh_wr_cnt", {19'd0, wcnt}, 32'd4);
    exp_q = '{16'd20, 16'd21, 16'd22, 16'd23};
    stream4("fresh");

    // Reset on the second valid stream cycle.
    collect4(16'd30, 16'd31, 16'd32, 16'd33);
    rs = 1'b1;
    tick();
    rs = 1'b0;
    tick();
    chk("pre_rst_data0", {16'd0, dout}, 32'd30);
    tick();
    chk("pre_rst_data1", {16'd0, dout}, 32'd31);
    rst_n = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, vld}, 32'd0);
    chk("midrst_data", {16'd0, dout}, 32'd0);
    chk("midrst_state", {30'd0, st}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("postrst_valid", {31'd0, vld}, 32'd0);

    // Full-size map with a ramp.
    en_b = 1'b1;
    tick();
    sv_b = 1'b1;
    for (int i = 0; i < 7744; i++) begin
      mi_b = 16'(i);
      tick();
    end
    sv_b = 1'b0;
    en_b = 1'b0;
    chk("big_full", {31'd0, full_b}, 32'd1);
    chk("big_wr_cnt", {19'd0, wcnt_b}, 32'd7744);
    rs_b = 1'b1;
    tick();
    rs_b = 1'b0;
    chk("big_first_invalid", {31'd0, vld_b}, 32'd0);
    for (int i = 0; i < 7744; i++) begin
      tick();
      chk("big_valid", {31'd0, vld_b}, 32'd1);
      chk("big_data", {16'd0, dout_b}, i);
      chk("big_last", {31'd0, lst_b}, (i == 7743) ? 32'd1 : 32'd0);
    end
    tick();
    chk("big_valid_drop", {31'd0, vld_b}, 32'd0);
    chk("big_idle", {30'd0, st_b}, 32'd0);
    chk("big_ovf", {31'd0, ovf_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
